// File: rtl/hilo_acc_unit_pkg.sv
// Shared definitions for the HI/LO accumulate unit: widths, op codes and FSM states.
package hilo_acc_unit_pkg;

    localparam int REG_DATA_BUS_W = 32;
    localparam int HILO_DATA_W    = REG_DATA_BUS_W;

    typedef enum logic [2:0] {
        HILO_OP_NOP     = 3'b000,
        HILO_OP_WR_HI   = 3'b001,
        HILO_OP_WR_LO   = 3'b010,
        HILO_OP_WR_BOTH = 3'b011,
        HILO_OP_MUL     = 3'b100,
        HILO_OP_MADD    = 3'b101,
        HILO_OP_MSUB    = 3'b110,
        HILO_OP_RSVD    = 3'b111
    } hilo_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        S_LO = 2'b01,
        S_HI = 2'b10
    } hilo_state_e;

    function automatic logic is_mul_op(input hilo_op_e op);
        return (op == HILO_OP_MUL) || (op == HILO_OP_MADD) || (op == HILO_OP_MSUB);
    endfunction

endpackage

// File: rtl/hilo_acc_unit_if.sv
// Request/result bundle between the pipeline (master) and the HI/LO unit (slave).
interface hilo_acc_unit_if #(
    parameter int DATA_W = hilo_acc_unit_pkg::HILO_DATA_W
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic [2:0]        op_i;
    logic              signed_i;
    logic [DATA_W-1:0] hi_i;
    logic [DATA_W-1:0] lo_i;
    logic [DATA_W-1:0] a_i;
    logic [DATA_W-1:0] b_i;
    logic              flush_i;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;
    logic              done_o;

    modport master (
        output req_valid_i, op_i, signed_i, hi_i, lo_i, a_i, b_i, flush_i,
        input  req_ready_o, hi_o, lo_o, done_o
    );

    modport slave (
        input  req_valid_i, op_i, signed_i, hi_i, lo_i, a_i, b_i, flush_i,
        output req_ready_o, hi_o, lo_o, done_o
    );
endinterface

// File: rtl/hilo_mul_stage.sv
// Widening multiplier: sign- or zero-extends both operands, keeps the low 2*DATA_W bits.
module hilo_mul_stage
    import hilo_acc_unit_pkg::*;
#(
    parameter int DATA_W = HILO_DATA_W
) (
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic                is_signed,
    output logic [2*DATA_W-1:0] prod
);
    logic [2*DATA_W-1:0] a_ext;
    logic [2*DATA_W-1:0] b_ext;

    assign a_ext = is_signed ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
    assign b_ext = is_signed ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
    assign prod  = a_ext * b_ext;
endmodule

// File: rtl/hilo_acc_unit.sv
// Architectural HI/LO state with direct writes and a 3-edge MUL/MADD/MSUB path.
module hilo_acc_unit
    import hilo_acc_unit_pkg::*;
#(
    parameter int DATA_W = HILO_DATA_W
) (
    input logic            clk,
    input logic            rst,
    hilo_acc_unit_if.slave bus
);
    hilo_state_e         state, next_state;
    hilo_op_e            req_op, op_q;
    logic [2*DATA_W-1:0] mul_prod, prod;
    logic [DATA_W-1:0]   hi_q, lo_q, lo_tmp, hi_calc;
    logic [DATA_W:0]     lo_calc;
    logic                carry, done_q, accept;

    assign req_op = hilo_op_e'(bus.op_i);
    assign accept = bus.req_valid_i && (state == IDLE) && !bus.flush_i;

    assign bus.req_ready_o = (state == IDLE);
    assign bus.hi_o        = hi_q;
    assign bus.lo_o        = lo_q;
    assign bus.done_o      = done_q;

    hilo_mul_stage #(.DATA_W(DATA_W)) u_mul (
        .a         (bus.a_i),
        .b         (bus.b_i),
        .is_signed (bus.signed_i),
        .prod      (mul_prod)
    );

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept && is_mul_op(req_op)) next_state = S_LO;
            S_LO:    next_state = bus.flush_i ? IDLE : S_HI;
            S_HI:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Bit DATA_W of lo_calc is the carry out (MADD) or borrow out (MSUB) of the low half.
    always_comb begin
        lo_calc = {1'b0, prod[DATA_W-1:0]};
        hi_calc = prod[2*DATA_W-1:DATA_W];
        case (op_q)
            HILO_OP_MADD: begin
                lo_calc = {1'b0, lo_q} + {1'b0, prod[DATA_W-1:0]};
                hi_calc = hi_q + prod[2*DATA_W-1:DATA_W] + DATA_W'(carry);
            end
            HILO_OP_MSUB: begin
                lo_calc = {1'b0, lo_q} - {1'b0, prod[DATA_W-1:0]};
                hi_calc = hi_q - prod[2*DATA_W-1:DATA_W] - DATA_W'(carry);
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: all datapath registers, not just the FSM, are cleared so a reset mid-op leaves no residue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            op_q   <= HILO_OP_NOP;
            prod   <= '0;
            lo_tmp <= '0;
            carry  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= next_state;
            done_q <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    case (req_op)
                        HILO_OP_WR_HI:   hi_q <= bus.hi_i;
                        HILO_OP_WR_LO:   lo_q <= bus.lo_i;
                        HILO_OP_WR_BOTH: begin
                            hi_q <= bus.hi_i;
                            lo_q <= bus.lo_i;
                        end
                        HILO_OP_MUL, HILO_OP_MADD, HILO_OP_MSUB: begin
                            prod <= mul_prod;
                            op_q <= req_op;
                        end
                        default: ;
                    endcase
                end
                S_LO: if (!bus.flush_i) begin
                    lo_tmp <= lo_calc[DATA_W-1:0];
                    carry  <= lo_calc[DATA_W];
                end
                S_HI: if (!bus.flush_i) begin
                    hi_q   <= hi_calc;
                    lo_q   <= lo_tmp;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_acc_unit.sv
// Randomised and directed checks of hilo_acc_unit against a 64-bit accumulator model.
module tb_hilo_acc_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [W-1:0] hi_m = '0;
    logic [W-1:0] lo_m = '0;

    always #5 clk = ~clk;

    hilo_acc_unit_if #(.DATA_W(W)) bus ();
    hilo_acc_unit #(.DATA_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] full_prod(input logic [W-1:0] a, b, input logic sgn);
        longint sa, sb;
        sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        return 64'(sa * sb);
    endfunction

    task automatic check_state(input string tag, input logic rdy, input logic dn);
        check({tag, "_hi"}, 64'(bus.hi_o), 64'(hi_m));
        check({tag, "_lo"}, 64'(bus.lo_o), 64'(lo_m));
        check({tag, "_ready"}, 64'(bus.req_ready_o), 64'(rdy));
        check({tag, "_done"}, 64'(bus.done_o), 64'(dn));
    endtask

    // flush_at: 0 none, 1 flush in S_LO, 2 flush in S_HI. drop: flush on the accept cycle.
    task automatic run_op(input logic [2:0] op, input logic sgn, input logic [W-1:0] h, l, a, b,
                          input int flush_at, input bit drop);
        logic [63:0] acc;
        check("ready_pre", 64'(bus.req_ready_o), 64'd1);
        bus.op_i = op; bus.signed_i = sgn; bus.hi_i = h; bus.lo_i = l;
        bus.a_i = a; bus.b_i = b; bus.req_valid_i = 1'b1; bus.flush_i = drop;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0; bus.flush_i = 1'b0;
        if (!drop) begin
            case (op)
                3'd1: hi_m = h;
                3'd2: lo_m = l;
                3'd3: begin hi_m = h; lo_m = l; end
                default: ;
            endcase
        end
        if (drop || op < 3'd4 || op == 3'd7) begin
            check_state("direct", 1'b1, 1'b0);
            return;
        end
        acc = full_prod(a, b, sgn);
        if (op == 3'd5) acc = {hi_m, lo_m} + acc;
        if (op == 3'd6) acc = {hi_m, lo_m} - acc;
        check_state("busy1", 1'b0, 1'b0);
        // A write offered while busy must be ignored.
        bus.op_i = 3'd1; bus.hi_i = $urandom; bus.req_valid_i = 1'b1;
        bus.flush_i = (flush_at == 1);
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        if (flush_at == 1) begin
            bus.req_valid_i = 1'b0;
            check_state("flush_slo", 1'b1, 1'b0);
            return;
        end
        check_state("busy2", 1'b0, 1'b0);
        bus.flush_i = (flush_at == 2);
        @(posedge clk); #1;
        bus.flush_i = 1'b0; bus.req_valid_i = 1'b0;
        if (flush_at == 2) begin
            check_state("flush_shi", 1'b1, 1'b0);
            return;
        end
        {hi_m, lo_m} = acc;
        check_state("commit", 1'b1, 1'b1);
        @(posedge clk); #1;
        check_state("post", 1'b1, 1'b0);
    endtask

    initial begin
        bus.req_valid_i = 1'b0; bus.op_i = '0; bus.signed_i = 1'b0; bus.flush_i = 1'b0;
        bus.hi_i = '0; bus.lo_i = '0; bus.a_i = '0; bus.b_i = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_state("reset", 1'b1, 1'b0);

        // Asynchronous reset mid-cycle wipes a non-zero state immediately.
        run_op(3'd3, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1 hi_m = '0; lo_m = '0;
        check_state("async_rst", 1'b1, 1'b0);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        run_op(3'd3, 0, 32'h12345678, 32'h9ABCDEF0, 0, 0, 0, 0);
        run_op(3'd2, 0, 32'hFFFF0000, 32'h00000001, 0, 0, 0, 0);
        run_op(3'd4, 1, 0, 0, 32'hFFFFFFFE, 32'h3, 0, 0);
        check("smul_hi", 64'(bus.hi_o), 64'hFFFFFFFF);
        run_op(3'd4, 0, 0, 0, 32'hFFFFFFFE, 32'h3, 0, 0);
        check("umul_hi", 64'(bus.hi_o), 64'h2);
        run_op(3'd3, 0, 32'h0, 32'hFFFFFFFF, 0, 0, 0, 0);
        run_op(3'd5, 0, 0, 0, 32'h1, 32'h1, 0, 0);
        check("madd_carry", {32'(bus.hi_o), 32'(bus.lo_o)}, 64'h00000001_00000000);
        run_op(3'd3, 0, 32'h1, 32'h0, 0, 0, 0, 0);
        run_op(3'd6, 1, 0, 0, 32'h1, 32'h1, 0, 0);
        check("msub_borrow", {32'(bus.hi_o), 32'(bus.lo_o)}, 64'h00000000_FFFFFFFF);
        run_op(3'd3, 0, 32'h0, 32'h0, 0, 0, 0, 0);
        run_op(3'd6, 1, 0, 0, 32'h1, 32'h1, 0, 0);
        check("msub_wrap", {32'(bus.hi_o), 32'(bus.lo_o)}, 64'hFFFFFFFF_FFFFFFFF);

        run_op(3'd5, 0, 0, 0, 32'h1234, 32'h5678, 2, 0);
        run_op(3'd5, 1, 0, 0, 32'hFFFF1234, 32'h5678, 1, 0);
        run_op(3'd3, 0, 32'hAAAA5555, 32'h5555AAAA, 0, 0, 0, 1);

        // Reset pulse while in S_LO discards the partial result.
        run_op(3'd3, 0, 32'h11111111, 32'h22222222, 0, 0, 0, 0);
        bus.op_i = 3'd5; bus.a_i = 32'h7; bus.b_i = 32'h9; bus.req_valid_i = 1'b1;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        #2 rst = 1'b1;
        #1 hi_m = '0; lo_m = '0;
        check_state("rst_slo", 1'b1, 1'b0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check_state("rst_slo_after", 1'b1, 1'b0);

        for (int i = 0; i < 60; i++) begin
            logic [2:0] op;
            int fa;
            op = 3'($urandom_range(0, 7));
            fa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
            run_op(op, 1'($urandom), $urandom, $urandom, $urandom, $urandom, fa,
                   ($urandom_range(0, 9) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hilo_acc_unit.md
Name: hilo_acc_unit

Overview:
- Parametrised successor to the HI/LO register pair; owns the architectural HI/LO state for the EX/WB stages.
- Supports direct writes to HI, LO or both, plus multi-cycle multiply, multiply-add and multiply-subtract (MUL/MADD/MSUB, signed or unsigned) into {HI,LO}.
- Uses a valid/ready handshake, so the pipeline control stalls on ready_o.
- Multi-cycle ops are abortable by flush_i.

Parameters:
- DATA_W, 32, width of HI, LO and each multiplier operand.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  unit can accept a request (high only in IDLE).
- op_i  in  3  000 NOP, 001 WR_HI, 010 WR_LO, 011 WR_BOTH, 100 MUL, 101 MADD, 110 MSUB, 111 reserved (treated as NOP).
- signed_i  in  1  operands a_i/b_i are two's complement (1) or unsigned (0).
- hi_i  in  DATA_W  write data for HI.
- lo_i  in  DATA_W  write data for LO.
- a_i  in  DATA_W  multiplier operand A.
- b_i  in  DATA_W  multiplier operand B.
- flush_i  in  1  abort any in-flight op; drop any same-cycle request.
- hi_o  out  DATA_W  architectural HI.
- lo_o  out  DATA_W  architectural LO.
- done_o  out  1  one-cycle pulse after a multi-cycle op commits.

Behaviour:
- Reset (async, rst=1):
  - hi_o=0, lo_o=0, done_o=0.
  - state=IDLE, so req_ready_o=1 once rst deasserts.
  - Internal prod/lo_tmp/carry registers are cleared.
- A request is accepted on a rising edge with req_valid_i & req_ready_o & ~flush_i.
- States: IDLE, S_LO, S_HI.
- Direct writes: accepted in IDLE and committed at the same edge (E0). Visible on hi_o/lo_o the next cycle; state stays IDLE.
  - WR_HI updates HI only.
  - WR_LO updates LO only.
  - WR_BOTH updates both.
  - NOP/reserved: no change.
- MUL/MADD/MSUB, edge by edge:
  - E0 (accept): prod (2*DATA_W) <= a_i*b_i. Operands are sign-extended if signed_i, else zero-extended; the product is taken modulo 2^(2*DATA_W). Op is latched. IDLE->S_LO.
  - E1 (S_LO): lo_tmp <= per op, with carry/borrow captured for ADD/SUB. S_LO->S_HI.
    - MUL: prod_lo.
    - MADD: lo_o + prod_lo.
    - MSUB: lo_o - prod_lo.
  - E2 (S_HI): hi_o <= per op; lo_o <= lo_tmp at the same edge (atomic commit). done_o <= 1 for exactly one cycle. S_HI->IDLE.
    - MUL: prod_hi.
    - MADD: hi_o + prod_hi + carry.
    - MSUB: hi_o - prod_hi - borrow.
  - hi_o/lo_o never show a half-updated value; they are unchanged until E2.
- Accumulation arithmetic is modulo 2^(2*DATA_W). No overflow flag, no saturation.
- Latency: accept-to-visible is 1 cycle for writes and 3 cycles for MUL/MADD/MSUB. The next request can be accepted in the cycle after E2.
- req_ready_o=0 in S_LO/S_HI. Requests presented while busy are ignored and not queued; the requester holds req_valid_i.
- flush_i:
  - In S_LO/S_HI: next state IDLE, no commit, done_o stays 0, HI/LO unchanged.
  - In IDLE: the same-cycle request is dropped.
  - flush_i has priority over the commit at E2. If flush_i=1 on the S_HI edge, no commit occurs.
- Async reset mid-op: immediate return to reset values; the partial result is discarded.
- done_o is 0 in every cycle except the one following E2.

Decomposition:
- Shared package/defines file holds:
  - op encodings (HILO_OP_NOP..HILO_OP_MSUB);
  - state encodings;
  - DATA_W default alongside the existing RegDataBus width define.
- One natural sub-module: hilo_mul_stage, which does the signed/unsigned widening multiply feeding the prod register.
- The FSM and the add/sub split stay in the top.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with prior hi=lo=0xDEADBEEF -> hi_o=lo_o=0, req_ready_o=1, done_o=0 immediately.
- Direct writes:
  - WR_BOTH hi_i=0x12345678, lo_i=0x9ABCDEF0 -> both visible the next cycle, ready stays 1.
  - Then WR_LO lo_i=0x1 -> lo=0x1, hi unchanged.
- Signed MUL: a=0xFFFFFFFE, b=0x00000003, signed=1 -> after 3 edges hi=0xFFFFFFFF, lo=0xFFFFFFFA, done_o pulses once.
  - Unsigned, same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- MADD carry: preset hi=0, lo=0xFFFFFFFF; MADD a=1, b=1 unsigned -> hi=0x00000001, lo=0x00000000.
  - req_ready_o=0 for exactly 2 cycles; a WR_HI presented while busy is ignored.
- MSUB borrow: preset hi=1, lo=0; MSUB a=1, b=1 signed -> hi=0, lo=0xFFFFFFFF.
  - Preset hi=0, lo=0 -> hi=lo=0xFFFFFFFF (wrap).
- Flush/reset mid-op:
  - MADD, with flush_i=1 in S_HI -> HI/LO unchanged, no done_o, ready=1 next cycle.
  - Repeat with rst pulse in S_LO -> hi=lo=0.
  - flush_i with WR_BOTH in IDLE -> no write.
